// File: rtl/laser_shot_if.sv
// Signal bundle between the laser stage and its neighbours (ship, alien block,
// pixel compositor). The slave side is the laser stage itself.
interface laser_shot_if;
   logic       fire;
   logic       frameTick;
   logic       hit;
   logic [9:0] gunPosition;
   logic [9:0] hPos;
   logic [9:0] vPos;
   logic [9:0] laserX;
   logic [9:0] laserY;
   logic       active;
   logic [2:0] color;
   logic [1:0] dbg_state;

   // No valid/ready handshake here: every input is sampled on each clk edge,
   // frameTick is a one-cycle strobe, and every output is a registered level.
   modport slave (
      input  fire, frameTick, hit, gunPosition, hPos, vPos,
      output laserX, laserY, active, color, dbg_state
   );

   modport master (
      output fire, frameTick, hit, gunPosition, hPos, vPos,
      input  laserX, laserY, active, color, dbg_state
   );
endinterface

// File: rtl/laser_shot.sv
// Player laser: launches one shot from the gun muzzle on a fire press, climbs
// once per frame tick, retires on a hit or at the screen edge, then cools down.
module laser_shot #(
   parameter int       SCREEN_HEIGHT   = 480,
   parameter int       V_OFFSET        = 10,
   parameter int       SHIP_HEIGHT     = 30,
   parameter int       LASER_WIDTH     = 4,
   parameter int       LASER_HEIGHT    = 12,
   parameter int       LASER_STEP      = 8,
   parameter int       COOLDOWN_FRAMES = 10,
   parameter logic [2:0] LASER         = 3'd6,
   parameter logic [2:0] NONE          = 3'd7
) (
   input  logic        clk,
   input  logic        reset,
   laser_shot_if.slave bus
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_FLYING   = 2'd1;
   localparam logic [1:0] ST_COOLDOWN = 2'd2;

   localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

   localparam logic [9:0]    SPAWN_Y  = 10'(V_OFFSET + SHIP_HEIGHT);
   localparam logic [9:0]    STEP_10  = 10'(LASER_STEP);
   localparam logic [10:0]   STEP_11  = 11'(LASER_STEP);
   localparam logic [10:0]   HEIGHT   = 11'(LASER_HEIGHT);
   localparam logic [10:0]   EDGE_Y   = 11'(SCREEN_HEIGHT - V_OFFSET);
   localparam logic [10:0]   HALF_W   = 11'(LASER_WIDTH / 2);
   localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN_FRAMES);
   localparam logic [CW-1:0] CD_ONE   = CW'(1);

   logic [1:0]    state_q, state_d;
   logic          fire_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          active_q, active_d;
   logic [2:0]    color_q, color_d;

   logic          fire_edge;
   logic [10:0]   y_ext;
   logic          edge_exit;

   assign fire_edge = bus.fire & ~fire_q;
   assign y_ext     = {1'b0, y_q};
   // 11-bit sum so the look-ahead past the bottom margin cannot wrap.
   assign edge_exit = (y_ext + STEP_11 + HEIGHT) > EDGE_Y;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         ST_IDLE: begin
            if (fire_edge) begin
               x_d     = bus.gunPosition;
               y_d     = SPAWN_Y;
               state_d = ST_FLYING;
            end
         end
         ST_FLYING: begin
            // A hit outranks the frame tick; coordinates freeze on retirement.
            if (bus.hit || (bus.frameTick && edge_exit)) begin
               cnt_d   = CD_LOAD;
               state_d = ST_COOLDOWN;
            end else if (bus.frameTick) begin
               y_d = y_q + STEP_10;
            end
         end
         ST_COOLDOWN: begin
            if (bus.frameTick) begin
               cnt_d = cnt_q - CD_ONE;
               if (cnt_q == CD_ONE) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign active_d = (state_d == ST_FLYING);

   logic signed [11:0] left_s;
   logic signed [11:0] h_s;
   logic [10:0]        right_ext;
   logic [10:0]        bottom_ext;
   logic               in_h;
   logic               in_v;

   // Left bound is signed so a laser near x=0 clips instead of wrapping high.
   assign left_s     = $signed({1'b0, x_q, 1'b0} >> 1) - $signed({1'b0, HALF_W});
   assign h_s        = $signed({2'b00, bus.hPos});
   assign right_ext  = {1'b0, x_q} + HALF_W;
   assign bottom_ext = y_ext + HEIGHT;
   assign in_h       = (h_s >= left_s) && ({1'b0, bus.hPos} < right_ext);
   assign in_v       = ({1'b0, bus.vPos} >= y_ext) && ({1'b0, bus.vPos} < bottom_ext);

   always_comb begin
      color_d = NONE;
      if ((state_q == ST_FLYING) && in_h && in_v) begin
         color_d = LASER;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         fire_q   <= 1'b0;
         cnt_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         active_q <= 1'b0;
         color_q  <= NONE;
      end else begin
         state_q  <= state_d;
         fire_q   <= bus.fire;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         active_q <= active_d;
         color_q  <= color_d;
      end
   end

   assign bus.laserX    = x_q;
   assign bus.laserY    = y_q;
   assign bus.active    = active_q;
   assign bus.color     = color_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_laser_shot.sv
// Self-checking bench for laser_shot: directed scenarios plus a randomized run,
// all checked against a frame-level behavioural model of the laser.
module tb_laser_shot;

   logic clk;
   logic reset;
   laser_shot_if bus();

   laser_shot dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors;
   int miscompares;

   // Behavioural model: a laser is either in flight, cooling down for some
   // number of remaining frames, or ready.
   bit m_fly;
   int m_x, m_y, m_cool, m_color;
   bit m_prev_fire;

   function automatic void model_step(input bit rst, input bit f, input bit ft, input bit ht,
                                      input int gun, input int h, input int v);
      bit press;
      if (rst) begin
         m_fly = 0; m_x = 0; m_y = 0; m_cool = 0; m_color = 7; m_prev_fire = 0;
         return;
      end
      press = f && !m_prev_fire;
      m_color = (m_fly && h >= m_x - 2 && h < m_x + 2 && v >= m_y && v < m_y + 12) ? 6 : 7;
      if (m_fly) begin
         if (ht || (ft && m_y + 8 + 12 > 470)) begin
            m_fly = 0;
            m_cool = 10;
         end else if (ft) begin
            m_y = m_y + 8;
         end
      end else if (m_cool > 0) begin
         if (ft) m_cool = m_cool - 1;
      end else if (press) begin
         m_fly = 1;
         m_x = gun;
         m_y = 40;
      end
      m_prev_fire = f;
   endfunction

   task automatic cycle(input bit rst, input bit f, input bit ft, input bit ht,
                        input int gun, input int h, input int v);
      reset           = rst;
      bus.fire        = f;
      bus.frameTick   = ft;
      bus.hit         = ht;
      bus.gunPosition = 10'(gun);
      bus.hPos        = 10'(h);
      bus.vPos        = 10'(v);
      model_step(rst, f, ft, ht, gun, h, v);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      cycle(1, 1, 0, 0, 320, 320, 40);
      cycle(1, 1, 1, 1, 320, 320, 40);
      vectors++; if (bus.active !== 1'b0) begin miscompares++; $display("FAIL reset_active got %0d want 0", bus.active); end
      vectors++; if (bus.color !== 3'd7) begin miscompares++; $display("FAIL reset_color got %0d want 7", bus.color); end
      vectors++; if (bus.laserX !== 10'd0) begin miscompares++; $display("FAIL reset_x got %0d want 0", bus.laserX); end
      vectors++; if (bus.laserY !== 10'd0) begin miscompares++; $display("FAIL reset_y got %0d want 0", bus.laserY); end
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 320, 0, 0);
      vectors++; if (bus.active !== 1'b0) begin miscompares++; $display("FAIL idle_no_fire got %0d want 0", bus.active); end
   endtask

   task automatic test_launch;
      cycle(0, 1, 0, 0, 320, 0, 0);
      vectors++; if (bus.active !== 1'b1) begin miscompares++; $display("FAIL launch_active got %0d want 1", bus.active); end
      vectors++; if (bus.laserX !== 10'd320) begin miscompares++; $display("FAIL launch_x got %0d want 320", bus.laserX); end
      vectors++; if (bus.laserY !== 10'd40) begin miscompares++; $display("FAIL launch_y got %0d want 40", bus.laserY); end
      cycle(0, 1, 0, 0, 400, 0, 0);
      cycle(0, 0, 0, 0, 400, 0, 0);
      vectors++; if (bus.laserX !== 10'd320) begin miscompares++; $display("FAIL gun_sampled_once got %0d want 320", bus.laserX); end
   endtask

   task automatic test_flight_colour;
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 400, 0, 0);
      vectors++; if (bus.laserY !== 10'd64) begin miscompares++; $display("FAIL flight_y got %0d want 64", bus.laserY); end
      cycle(0, 0, 0, 0, 400, 319, 64);
      vectors++; if (bus.color !== 3'd6) begin miscompares++; $display("FAIL pix_319_64 got %0d want 6", bus.color); end
      cycle(0, 0, 0, 0, 400, 322, 64);
      vectors++; if (bus.color !== 3'd7) begin miscompares++; $display("FAIL pix_322_64 got %0d want 7", bus.color); end
      cycle(0, 0, 0, 0, 400, 320, 76);
      vectors++; if (bus.color !== 3'd7) begin miscompares++; $display("FAIL pix_320_76 got %0d want 7", bus.color); end
      cycle(0, 0, 0, 0, 400, 318, 75);
      vectors++; if (bus.color !== 3'd6) begin miscompares++; $display("FAIL pix_318_75 got %0d want 6", bus.color); end
      cycle(0, 0, 0, 0, 400, 317, 64);
      vectors++; if (bus.color !== 3'd7) begin miscompares++; $display("FAIL pix_317_64 got %0d want 7", bus.color); end
      cycle(0, 0, 0, 0, 400, 320, 63);
      vectors++; if (bus.color !== 3'd7) begin miscompares++; $display("FAIL pix_320_63 got %0d want 7", bus.color); end
   endtask

   task automatic test_edge_exit;
      int guard;
      guard = 0;
      while (bus.laserY !== 10'd456 && guard < 60) begin
         cycle(0, 0, 1, 0, 400, 0, 0);
         guard++;
      end
      vectors++; if (bus.laserY !== 10'd456) begin miscompares++; $display("FAIL climb_to_456 got %0d want 456", bus.laserY); end
      vectors++; if (bus.active !== 1'b1) begin miscompares++; $display("FAIL at_456_active got %0d want 1", bus.active); end
      cycle(0, 0, 1, 0, 400, 0, 0);
      vectors++; if (bus.active !== 1'b0) begin miscompares++; $display("FAIL edge_retire got %0d want 0", bus.active); end
      vectors++; if (bus.laserY !== 10'd456) begin miscompares++; $display("FAIL edge_no_move got %0d want 456", bus.laserY); end
      for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 400, 0, 0);
      cycle(0, 1, 0, 0, 400, 0, 0);
      vectors++; if (bus.active !== 1'b0) begin miscompares++; $display("FAIL cooldown_9_lock got %0d want 0", bus.active); end
      cycle(0, 0, 0, 0, 400, 0, 0);
      cycle(0, 0, 1, 0, 400, 0, 0);
      cycle(0, 1, 0, 0, 100, 0, 0);
      vectors++; if (bus.active !== 1'b1) begin miscompares++; $display("FAIL refire_after_10 got %0d want 1", bus.active); end
      vectors++; if (bus.laserX !== 10'd100) begin miscompares++; $display("FAIL refire_x got %0d want 100", bus.laserX); end
      cycle(0, 0, 0, 0, 100, 0, 0);
   endtask

   task automatic test_hit_priority;
      cycle(0, 0, 1, 0, 100, 0, 0);
      cycle(0, 0, 1, 0, 100, 0, 0);
      cycle(0, 0, 1, 1, 100, 0, 0);
      vectors++; if (bus.active !== 1'b0) begin miscompares++; $display("FAIL hit_retire got %0d want 0", bus.active); end
      vectors++; if (bus.laserY !== 10'd56) begin miscompares++; $display("FAIL hit_y_hold got %0d want 56", bus.laserY); end
      cycle(0, 1, 0, 0, 100, 0, 0);
      cycle(0, 0, 0, 0, 100, 0, 0);
      vectors++; if (bus.active !== 1'b0) begin miscompares++; $display("FAIL cooldown_fire_ignored got %0d want 0", bus.active); end
      for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 100, 0, 0);
   endtask

   task automatic test_refire_lockout;
      cycle(0, 1, 0, 0, 1, 0, 0);
      vectors++; if (bus.active !== 1'b1) begin miscompares++; $display("FAIL lockout_launch got %0d want 1", bus.active); end
      cycle(0, 1, 0, 0, 1, 0, 40);
      vectors++; if (bus.color !== 3'd6) begin miscompares++; $display("FAIL clip_pix_0 got %0d want 6", bus.color); end
      cycle(0, 1, 0, 0, 1, 1023, 40);
      vectors++; if (bus.color !== 3'd7) begin miscompares++; $display("FAIL clip_pix_1023 got %0d want 7", bus.color); end
      cycle(0, 1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 1, 0, 0);
      vectors++; if (bus.active !== 1'b0) begin miscompares++; $display("FAIL held_fire_no_relaunch got %0d want 0", bus.active); end
      cycle(0, 0, 0, 0, 200, 0, 0);
      cycle(0, 1, 0, 0, 200, 0, 0);
      vectors++; if (bus.active !== 1'b1) begin miscompares++; $display("FAIL press_after_release got %0d want 1", bus.active); end
      vectors++; if (bus.laserX !== 10'd200) begin miscompares++; $display("FAIL press_after_release_x got %0d want 200", bus.laserX); end
   endtask

   task automatic test_reset_in_flight;
      cycle(1, 0, 0, 0, 200, 200, 40);
      vectors++; if (bus.active !== 1'b0) begin miscompares++; $display("FAIL flight_reset_active got %0d want 0", bus.active); end
      vectors++; if (bus.color !== 3'd7) begin miscompares++; $display("FAIL flight_reset_color got %0d want 7", bus.color); end
      cycle(0, 0, 0, 0, 200, 0, 0);
   endtask

   task automatic test_random;
      bit f, ft, ht;
      int gun, h, v, d;
      f = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) f = ~f;
         ft  = ($urandom_range(0, 3) == 0);
         ht  = ($urandom_range(0, 60) == 0);
         gun = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 0) begin
            d = int'($urandom_range(0, 6)) - 3;
            h = m_x + d;
            d = int'($urandom_range(0, 16)) - 2;
            v = m_y + d;
         end else begin
            h = int'($urandom_range(0, 1023));
            v = int'($urandom_range(0, 1023));
         end
         if (h < 0) h = 0;
         if (h > 1023) h = 1023;
         if (v < 0) v = 0;
         if (v > 1023) v = 1023;
         cycle(($urandom_range(0, 400) == 0), f, ft, ht, gun, h, v);
         vectors++; if (bus.active !== m_fly) begin miscompares++; $display("FAIL rand_active[%0d] got %0d want %0d", n, bus.active, m_fly); end
         vectors++; if (bus.laserX !== 10'(m_x)) begin miscompares++; $display("FAIL rand_x[%0d] got %0d want %0d", n, bus.laserX, m_x); end
         vectors++; if (bus.laserY !== 10'(m_y)) begin miscompares++; $display("FAIL rand_y[%0d] got %0d want %0d", n, bus.laserY, m_y); end
         vectors++; if (bus.color !== 3'(m_color)) begin miscompares++; $display("FAIL rand_color[%0d] got %0d want %0d", n, bus.color, m_color); end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b1;
      bus.fire = 1'b0; bus.frameTick = 1'b0; bus.hit = 1'b0;
      bus.gunPosition = '0; bus.hPos = '0; bus.vPos = '0;
      test_reset();
      test_launch();
      test_flight_colour();
      test_edge_exit();
      test_hit_priority();
      test_refire_lockout();
      test_reset_in_flight();
      cycle(1, 0, 0, 0, 0, 0, 0);
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1);
   end

endmodule
